ifetch_prefetch: RTL
====================

Name: ifetch_prefetch

Overview:
- Parametrised successor to the single-PC fetch stage: pipelined instruction fetch unit with a prefetch FIFO.
- Drives an external instruction memory with fixed 1-cycle read latency and buffers {pc, instr} pairs.
- Hands pairs to decode over a valid/ready handshake.
- Computes branch and jump targets internally; flushes on redirect.

Parameters:
- ADDR_W, 32, PC/byte-address width; legal range is ADDR_W >= 28.
- FIFO_DEPTH, 4, prefetch entries; must be a power of two, >= 2.
- RESET_PC, 0, PC loaded on reset; must be word aligned.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_en  out  1  read request this cycle.
- imem_addr  out  ADDR_W  byte address of request; bits [1:0] always 0.
- imem_rdata  in  32  read data, valid the cycle after imem_en.
- out_valid  out  1  head entry available.
- out_ready  in  1  decode accepts head.
- out_instr  out  32  head instruction.
- out_pc  out  ADDR_W  PC of head instruction.
- is_branch  in  1  taken-branch redirect request.
- is_jump  in  1  jump redirect request.
- branch_offset  in  16  signed word offset.
- jump_addr  in  26  jump word index.
- base_pc  in  ADDR_W  PC of the redirecting instruction.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- One clock (clk). Reset is synchronous, active-high.
- Reset: fetch_pc=RESET_PC, FIFO empty, in-flight flag cleared, out_valid=0, fifo_count=0, imem_en=0. Reset overrides every other input.
- Issue: imem_en=1 and imem_addr=fetch_pc when (fifo_count + inflight) < FIFO_DEPTH and no redirect this cycle. On issue, fetch_pc <= fetch_pc+4, wrapping modulo 2^ADDR_W.
- Response: imem_rdata in the cycle after issue is pushed with its PC at that clock edge, unless squashed.
  - Issue-to-out_valid latency: 2 cycles. No bypass.
  - The first fetch after reset deasserts in cycle 0 and appears in cycle 2.
- Credit scheme: the FIFO never overflows. A push is always accepted, including when a pop occurs in the same cycle.
- Output: out_valid = FIFO not empty. out_instr/out_pc come combinationally from the head. Pop on out_valid && out_ready. Order is strictly preserved.
- Throughput: 1 instruction/cycle sustained with out_ready held high.
- Redirect (is_branch | is_jump high):
  - FIFO cleared at the edge. A pop in the same cycle is ignored.
  - imem_en=0 that cycle. Any response arriving next cycle is discarded.
  - fetch_pc <= target. The target is fetched at R+1, and out_valid rises at R+3.
- Targets:
  - pc4 = base_pc+4.
  - Branch = pc4 + (sext(branch_offset) << 2), truncated to ADDR_W.
  - Jump = {pc4[ADDR_W-1:28], jump_addr, 2'b00}.
  - Both high: jump wins.
- Backpressure: when out_ready=0, fetch continues until fifo_count+inflight=FIFO_DEPTH, then imem_en=0 until a pop frees a slot. The issue resumes in the same cycle as the pop.

Test Plan:
- Reset release, out_ready=1, imem_rdata = addr ^ 0xA5A5_0000 -> out_pc 0x0,0x4,0x8... on consecutive cycles from cycle 2; out_instr matches; fifo_count <= 1.
- FIFO_DEPTH=4, out_ready=0 -> exactly four issues (0x0,0x4,0x8,0xC), imem_en then low, fifo_count=4. Raise out_ready -> drains 0x0..0xC in order, issue 0x10 the same cycle as the first pop.
- Branch at cycle R, base_pc=0x40, branch_offset=0xFFFE -> target 0x3C; out_valid=0 in R+1 and R+2; the response to the R-1 issue is dropped; out_pc=0x3C at R+3.
- Jump, base_pc=0xF000_0010, jump_addr=0x000_0100 -> target 0xF000_0400. Repeat with is_branch also high -> still 0xF000_0400.
- Reset asserted with a full FIFO and a fetch in flight -> next cycle out_valid=0, fifo_count=0; then imem_addr=RESET_PC with imem_en=1 after release.
- RESET_PC=0xFFFF_FFF8 -> issued addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000 (wrap).

Source files
------------

// File: rtl/ifetch_prefetch.sv
// Pipelined instruction fetch with a credit-controlled prefetch FIFO of {pc, instr} pairs.
// Branch/jump targets are formed locally; a redirect flushes the FIFO and squashes the in-flight read.
module ifetch_prefetch #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    output logic                          imem_en,
    output logic [ADDR_W-1:0]             imem_addr,
    input  logic [31:0]                   imem_rdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_instr,
    output logic [ADDR_W-1:0]             out_pc,
    input  logic                          is_branch,
    input  logic                          is_jump,
    input  logic [15:0]                   branch_offset,
    input  logic [25:0]                   jump_addr,
    input  logic [ADDR_W-1:0]             base_pc,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = PTR_W + 2;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [ADDR_W-1:0] mem_pc_q    [FIFO_DEPTH];
    logic [31:0]       mem_instr_q [FIFO_DEPTH];

    logic              redirect, push, pop, issue;
    logic [OCC_W-1:0]  occupancy, limit;
    logic [ADDR_W-1:0] pc4, branch_tgt, jump_tgt, target;

    assign pc4        = base_pc + ADDR_W'(4);
    assign branch_tgt = pc4 + {{(ADDR_W-18){branch_offset[15]}}, branch_offset, 2'b00};

    if (ADDR_W > 28) begin : g_jump_region
        assign jump_tgt = {pc4[ADDR_W-1:28], jump_addr, 2'b00};
    end else begin : g_jump_flat
        assign jump_tgt = {jump_addr, 2'b00};
    end

    assign target   = is_jump ? jump_tgt : branch_tgt;
    assign redirect = is_branch | is_jump;

    // A slot freed by this cycle's pop is already usable as credit for a new issue.
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready && !redirect;
    assign push      = inflight_q && !redirect;
    assign occupancy = OCC_W'(count_q) + OCC_W'(inflight_q);
    assign limit     = OCC_W'(FIFO_DEPTH) + OCC_W'(pop);
    assign issue     = !reset && !redirect && (occupancy < limit);

    assign imem_en    = issue;
    assign imem_addr  = fetch_pc_q;
    assign out_pc     = mem_pc_q[rd_ptr_q];
    assign out_instr  = mem_instr_q[rd_ptr_q];
    assign fifo_count = count_q;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = fetch_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (redirect) begin
            fetch_pc_d = target;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // NOTE: FIFO storage is not reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]    <= inflight_pc_q;
            mem_instr_q[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule
